// File: rtl/sad_accum_4b.sv
// Sum-of-absolute-differences accumulator for 4-bit operand pairs.
// Each accepted pair contributes |in0 - in1| to a saturating sum. After N
// pairs the block result is offered on a valid/ready output port.
module sad_accum_4b #(
  parameter int unsigned N     = 4,
  parameter int unsigned SUM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [3:0]       in0,
  input  logic [3:0]       in1,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_sat
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0]       r;
  logic [3:0]       diff;
  logic             bout;
  logic [3:0]       mag;
  logic [SUM_W:0]   sum_ext;

  // Subtractor result and its conversion to a magnitude, plus the widened add.
  always_comb begin
    r       = {1'b0, in0} - {1'b0, in1};
    diff    = r[3:0];
    bout    = r[4];
    mag     = bout ? (~diff + 4'd1) : diff;
    sum_ext = {1'b0, sum_q} + {{(SUM_W - 3){1'b0}}, mag};
  end

  // Next-state and handshake outputs; clr overrides every handshake.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    in_rdy  = (state_q == ACCUM);
    out_val = (state_q == DONE);

    if (clr) begin
      state_d = ACCUM;
      sum_d   = '0;
      sat_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_val) begin
            if (sum_ext[SUM_W]) begin
              sum_d = '1;
              sat_d = 1'b1;
            end else begin
              sum_d = sum_ext[SUM_W-1:0];
            end
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_rdy) begin
            sum_d   = '0;
            sat_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State, accumulator, sticky saturation flag and pair counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_sum = sum_q;
  assign out_sat = sat_q;

endmodule

// File: tb/tb_sad_accum_4b.sv
// Bench for sad_accum_4b: two instances (SUM_W 8 and 5) share one stimulus
// stream and are compared every cycle against a behavioural block model.
module tb_sad_accum_4b;

  localparam int unsigned NP = 4;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_val;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       out_rdy;

  logic       rdy8, val8, sat8;
  logic [7:0] sum8;
  logic       rdy5, val5, sat5;
  logic [4:0] sum5;

  int vectors;
  int miscompares;

  // Model: block progress is width independent; sums are kept per width.
  int  m_pairs;
  bit  m_done;
  int  m_sum [2];
  bit  m_sat [2];
  int  m_max [2];

  sad_accum_4b #(.N(NP), .SUM_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_val(in_val), .in_rdy(rdy8),
    .in0(in0), .in1(in1), .out_val(val8), .out_rdy(out_rdy),
    .out_sum(sum8), .out_sat(sat8)
  );

  sad_accum_4b #(.N(NP), .SUM_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_val(in_val), .in_rdy(rdy5),
    .in0(in0), .in1(in1), .out_val(val5), .out_rdy(out_rdy),
    .out_sum(sum5), .out_sat(sat5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pairs = 0;
    m_done  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_sum[i] = 0;
      m_sat[i] = 1'b0;
    end
  endtask

  task automatic model_clock();
    int a;
    int b;
    int mag;
    if (!rst_n || clr) begin
      model_reset();
    end else if (!m_done) begin
      if (in_val) begin
        a   = int'(in0);
        b   = int'(in1);
        mag = (a > b) ? a - b : b - a;
        for (int i = 0; i < 2; i++) begin
          if (m_sum[i] + mag > m_max[i]) begin
            m_sum[i] = m_max[i];
            m_sat[i] = 1'b1;
          end else begin
            m_sum[i] = m_sum[i] + mag;
          end
        end
        m_pairs++;
        if (m_pairs == int'(NP)) begin
          m_pairs = 0;
          m_done  = 1'b1;
        end
      end
    end else if (out_rdy) begin
      m_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_sum[i] = 0;
        m_sat[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("in_rdy8",  32'(rdy8), 32'(!m_done));
    chk("out_val8", 32'(val8), 32'(m_done));
    chk("out_sum8", 32'(sum8), 32'(m_sum[0]));
    chk("out_sat8", 32'(sat8), 32'(m_sat[0]));
    chk("in_rdy5",  32'(rdy5), 32'(!m_done));
    chk("out_val5", 32'(val5), 32'(m_done));
    chk("out_sum5", 32'(sum5), 32'(m_sum[1]));
    chk("out_sat5", 32'(sat5), 32'(m_sat[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic send(input int a, input int b);
    in_val = 1'b1;
    in0    = 4'(a);
    in1    = 4'(b);
    tick();
  endtask

  task automatic idle(input int cycles);
    in_val = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_max[0]    = 255;
    m_max[1]    = 31;
    rst_n   = 1'b0;
    clr     = 1'b0;
    in_val  = 1'b0;
    in0     = '0;
    in1     = '0;
    out_rdy = 1'b1;
    model_reset();

    // Reset state.
    #1;
    check_all();
    chk("rst_in_rdy",  32'(rdy8), 32'd1);
    chk("rst_out_val", 32'(val8), 32'd0);
    chk("rst_out_sum", 32'(sum8), 32'd0);
    tick();
    rst_n = 1'b1;
    idle(1);

    // Back-to-back block with the consumer ready.
    send(3, 5);
    send(9, 2);
    send(0, 15);
    send(7, 7);
    chk("t1_out_val", 32'(val8), 32'd1);
    chk("t1_out_sum", 32'(sum8), 32'd24);
    chk("t1_out_sat", 32'(sat8), 32'd0);
    chk("t1_in_rdy",  32'(rdy8), 32'd0);
    idle(1);
    chk("t1_in_rdy_after", 32'(rdy8), 32'd1);

    // Gap of two idle cycles inside a block.
    send(3, 5);
    send(9, 2);
    idle(1);
    chk("gap_sum_a", 32'(sum8), 32'd9);
    idle(1);
    chk("gap_sum_b", 32'(sum8), 32'd9);
    send(0, 15);
    send(7, 7);
    chk("gap_out_sum", 32'(sum8), 32'd24);
    idle(1);

    // Backpressure on the result port.
    send(3, 5);
    send(9, 2);
    send(0, 15);
    out_rdy = 1'b0;
    send(7, 7);
    in_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_sum", 32'(sum8), 32'd24);
      chk("bp_in_rdy",  32'(rdy8), 32'd0);
      chk("bp_out_val", 32'(val8), 32'd1);
    end
    out_rdy = 1'b1;
    idle(1);
    chk("bp_release_sum", 32'(sum8), 32'd0);
    chk("bp_release_rdy", 32'(rdy8), 32'd1);

    // Saturation in the narrow instance.
    send(15, 0);
    chk("sat_sum_1", 32'(sum5), 32'd15);
    send(15, 0);
    chk("sat_sum_2", 32'(sum5), 32'd30);
    send(15, 0);
    chk("sat_sum_3", 32'(sum5), 32'd31);
    chk("sat_flag_3", 32'(sat5), 32'd1);
    send(15, 0);
    chk("sat_out_sum", 32'(sum5), 32'd31);
    chk("sat_out_sat", 32'(sat5), 32'd1);
    idle(1);
    for (int i = 0; i < 4; i++) send(1, 0);
    chk("sat_next_sum", 32'(sum5), 32'd4);
    chk("sat_next_sat", 32'(sat5), 32'd0);
    idle(1);

    // clr discards the partial block and the pair offered with it.
    send(10, 2);
    send(10, 2);
    clr = 1'b1;
    send(5, 5);
    clr = 1'b0;
    chk("clr_sum", 32'(sum8), 32'd0);
    for (int i = 0; i < 4; i++) send(1, 3);
    chk("clr_out_sum", 32'(sum8), 32'd8);
    chk("clr_out_val", 32'(val8), 32'd1);

    // clr also drops a pending result.
    out_rdy = 1'b0;
    idle(1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    out_rdy = 1'b1;
    chk("clr_done_val", 32'(val8), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_val  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 31) == 0);
      in0     = 4'($urandom_range(0, 15));
      in1     = 4'($urandom_range(0, 15));
      tick();
    end
    clr     = 1'b0;
    out_rdy = 1'b1;
    idle(2);

    // Asynchronous reset between clock edges in the middle of a block.
    send(12, 1);
    send(2, 14);
    in_val = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_in_rdy",  32'(rdy8), 32'd1);
    chk("arst_out_val", 32'(val8), 32'd0);
    chk("arst_out_sum", 32'(sum8), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(6, 1);
    chk("arst_next_sum", 32'(sum8), 32'd20);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
